// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer. A prescaler turns TICKS_PER_SEC clock cycles into one
// countdown second. All outputs are registered and driven from a single FSM block.
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       pause,
    input  logic [7:0] load_bcd,
    output logic [8:0] seconds,
    output logic       busy,
    output logic       expired
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic [8:0]    seconds_q;
    logic          busy_q;
    logic          expired_q;

    logic [3:0]    load_tens_d;
    logic [3:0]    load_ones_d;
    logic [3:0]    dec_tens_d;
    logic [3:0]    dec_ones_d;
    logic          load_zero_c;
    logic          tick_c;
    logic          last_c;

    // Clamp non-BCD nibbles to 9 and prepare the one-second BCD decrement.
    always_comb begin
        load_tens_d = (load_bcd[7:4] > 4'd9) ? 4'd9 : load_bcd[7:4];
        load_ones_d = (load_bcd[3:0] > 4'd9) ? 4'd9 : load_bcd[3:0];
        load_zero_c = (load_tens_d == 4'd0) && (load_ones_d == 4'd0);
        if (ones_q == 4'd0) begin
            dec_tens_d = tens_q - 4'd1;
            dec_ones_d = 4'd9;
        end else begin
            dec_tens_d = tens_q;
            dec_ones_d = ones_q - 4'd1;
        end
        tick_c = (presc_q == PW'(TICKS_PER_SEC - 1));
        last_c = (tens_q == 4'd0) && (ones_q == 4'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            seconds_q <= 9'h000;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    // cancel outranks start, including cancel issued in IDLE
                    if (cancel) begin
                        state_q   <= IDLE;
                        presc_q   <= '0;
                        tens_q    <= 4'd0;
                        ones_q    <= 4'd0;
                        seconds_q <= 9'h000;
                        busy_q    <= 1'b0;
                    end else if (start) begin
                        presc_q <= '0;
                        tens_q  <= load_tens_d;
                        ones_q  <= load_ones_d;
                        if (load_zero_c) begin
                            state_q   <= DONE;
                            seconds_q <= 9'h100;
                            busy_q    <= 1'b0;
                            expired_q <= 1'b1;
                        end else begin
                            state_q   <= RUN;
                            seconds_q <= {1'b1, load_tens_d, load_ones_d};
                            busy_q    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        state_q   <= IDLE;
                        presc_q   <= '0;
                        tens_q    <= 4'd0;
                        ones_q    <= 4'd0;
                        seconds_q <= 9'h000;
                        busy_q    <= 1'b0;
                    end else if (!pause) begin
                        if (tick_c) begin
                            presc_q <= '0;
                            if (last_c) begin
                                state_q   <= DONE;
                                tens_q    <= 4'd0;
                                ones_q    <= 4'd0;
                                seconds_q <= 9'h100;
                                busy_q    <= 1'b0;
                                expired_q <= 1'b1;
                            end else begin
                                tens_q    <= dec_tens_d;
                                ones_q    <= dec_ones_d;
                                seconds_q <= {1'b1, dec_tens_d, dec_ones_d};
                            end
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    presc_q   <= '0;
                    seconds_q <= 9'h000;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign seconds = seconds_q;
    assign busy    = busy_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized checks of countdown_timer against a seconds-remaining
// reference model (integer arithmetic, no notion of the RTL's state machine).
module tb_countdown_timer;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cancel;
    logic       pause;
    logic [7:0] load_bcd;
    logic [8:0] seconds;
    logic       busy;
    logic       expired;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: seconds left, running flag, display-on flag, cycles into current second
    int rem     = 0;
    bit running = 1'b0;
    bit shown   = 1'b0;
    int elapsed = 0;
    bit pulse   = 1'b0;

    countdown_timer #(.TICKS_PER_SEC(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cancel   (cancel),
        .pause    (pause),
        .load_bcd (load_bcd),
        .seconds  (seconds),
        .busy     (busy),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        rem = 0; running = 1'b0; shown = 1'b0; elapsed = 0; pulse = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit ca, input bit pa, input logic [7:0] ld);
        int t, o;
        pulse = 1'b0;
        if (ca) begin
            running = 1'b0; shown = 1'b0; rem = 0; elapsed = 0;
        end else if (running) begin
            if (!pa) begin
                elapsed++;
                if (elapsed == int'(T)) begin
                    elapsed = 0;
                    rem--;
                    if (rem == 0) begin
                        running = 1'b0;
                        pulse   = 1'b1;
                    end
                end
            end
        end else if (st) begin
            t = (int'(ld[7:4]) > 9) ? 9 : int'(ld[7:4]);
            o = (int'(ld[3:0]) > 9) ? 9 : int'(ld[3:0]);
            rem = t * 10 + o;
            shown = 1'b1;
            elapsed = 0;
            if (rem == 0) pulse = 1'b1;
            else running = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_word();
        return 32'({shown, 4'(rem / 10), 4'(rem % 10), running, pulse});
    endfunction

    function automatic logic [31:0] dut_word();
        return 32'({seconds, busy, expired});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: drive inputs, advance model on the edge, compare #1 later
    task automatic cyc(input string tag, input bit st, input bit ca, input bit pa, input logic [7:0] ld);
        start = st; cancel = ca; pause = pa; load_bcd = ld;
        @(posedge clk);
        model_step(st, ca, pa, ld);
        #1;
        chk(tag, dut_word(), model_word());
    endtask

    initial begin
        int t_exp;
        int n_exp;
        logic [7:0] ld;

        reset = 1'b0; start = 1'b0; cancel = 1'b0; pause = 1'b0; load_bcd = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", dut_word(), 32'h0);
        reset = 1'b1;

        // 03: 103 -> 102 -> 101 -> 100 at 4-cycle spacing, single expired pulse
        cyc("r031_start", 1'b1, 1'b0, 1'b0, 8'h03);
        chk("r031_first", dut_word(), 32'({9'h103, 1'b1, 1'b0}));
        for (int k = 1; k <= 14; k++) cyc("r031_run", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("r031_done", dut_word(), 32'({9'h100, 1'b0, 1'b0}));
        cyc("idle_gap", 1'b0, 1'b1, 1'b0, 8'h00);

        // 10: borrow to 09 on the first tick, finish after ten seconds
        cyc("r032_start", 1'b1, 1'b0, 1'b0, 8'h10);
        for (int k = 1; k <= 4; k++) cyc("r032_run", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("r032_borrow", 32'(seconds), 32'(9'h109));
        for (int k = 5; k <= 42; k++) cyc("r032_run", 1'b0, 1'b0, 1'b0, 8'h00);

        // 05 with a 10-cycle pause mid-second: expired exactly 30 cycles after start
        cyc("r033_start", 1'b1, 1'b0, 1'b0, 8'h05);
        t_exp = -1;
        for (int k = 1; k <= 34; k++) begin
            cyc("r033_run", 1'b0, 1'b0, (k >= 6 && k <= 15), 8'h00);
            if (k == 15) chk("r033_frozen", 32'(seconds), 32'(9'h104));
            if (expired === 1'b1) t_exp = k;
        end
        chk("r033_latency", 32'(t_exp), 32'd30);

        // 02: cancel on the 01->00 tick suppresses expired
        cyc("r034_start", 1'b1, 1'b0, 1'b0, 8'h02);
        n_exp = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc("r034_run", 1'b0, (k == 8), 1'b0, 8'h00);
            if (expired === 1'b1) n_exp++;
        end
        chk("r034_no_expired", 32'(n_exp), 32'd0);
        chk("r034_blank", dut_word(), 32'h0);

        // clamping, zero load, start+cancel from DONE
        cyc("r035_clamp", 1'b1, 1'b0, 1'b0, 8'hAF);
        chk("r035_199", 32'(seconds), 32'(9'h199));
        cyc("r035_cancel", 1'b0, 1'b1, 1'b0, 8'h00);
        cyc("r035_clamp_lo", 1'b1, 1'b0, 1'b0, 8'h4F);
        chk("r035_149", 32'(seconds), 32'(9'h149));
        cyc("r035_cancel2", 1'b0, 1'b1, 1'b0, 8'h00);
        cyc("r035_zero", 1'b1, 1'b0, 1'b0, 8'h00);
        chk("r035_zero_exp", dut_word(), 32'({9'h100, 1'b0, 1'b1}));
        cyc("r035_done_hold", 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("r035_start_cancel", 1'b1, 1'b1, 1'b0, 8'h55);
        chk("r035_idle", dut_word(), 32'h0);

        // start ignored in RUN, including on a tick cycle
        cyc("r022_start", 1'b1, 1'b0, 1'b0, 8'h12);
        for (int k = 1; k <= 9; k++) cyc("r022_run", 1'b1, 1'b0, 1'b0, 8'h77);
        chk("r022_no_reload", 32'(seconds), 32'(9'h110));

        // asynchronous reset mid-RUN at 07
        cyc("r036_cancel", 1'b0, 1'b1, 1'b0, 8'h00);
        cyc("r036_start", 1'b1, 1'b0, 1'b0, 8'h07);
        cyc("r036_run", 1'b0, 1'b0, 1'b0, 8'h00);
        chk("r036_at_107", 32'(seconds), 32'(9'h107));
        reset = 1'b0;
        model_reset();
        #1;
        chk("r036_async", dut_word(), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) cyc("r036_stay_idle", 1'b0, 1'b0, 1'b0, 8'h00);
        cyc("r030_restart", 1'b1, 1'b0, 1'b0, 8'h07);
        chk("r030_first", dut_word(), 32'({9'h107, 1'b1, 1'b0}));

        // randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            ld = (($urandom % 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            cyc("random", (($urandom % 8) == 0), (($urandom % 40) == 0),
                (($urandom % 4) == 0), ld);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, clk cycles per countdown second (2..2^27); benches use 4.
REQ-002 SHALL have port clk  input  1  single system clock, all state on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse; arms countdown from load_bcd.
REQ-005 SHALL have port cancel  input  1  one-cycle pulse; aborts countdown and blanks display.
REQ-006 SHALL have port pause  input  1  level; freezes countdown while high in RUN.
REQ-007 SHALL have port load_bcd  input  8  start value: [7:4] tens BCD, [3:0] ones BCD.
REQ-008 SHALL have port seconds  output  9  display word: [8] countdown-active flag, [7:4] tens BCD, [3:0] ones BCD.
REQ-009 SHALL have port busy  output  1  high in RUN.
REQ-010 SHALL have port expired  output  1  one-cycle pulse on reaching 00.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE, all outputs registered.
REQ-012 IDLE: seconds=9'h000, busy=0; countdown display off.
REQ-013 start in IDLE or DONE SHALL latch sanitised load_bcd, clear prescaler; seconds[8]=1 and digits valid the next cycle.
REQ-014 Sanitise: any load_bcd nibble >9 SHALL be clamped to 9 (e.g. 8'hA3 -> 93, 8'h4F -> 49).
REQ-015 Sanitised value 00 SHALL go straight to DONE, expired high the cycle after start, seconds=9'h100.
REQ-016 Nonzero value SHALL go to RUN, busy=1 the cycle after start.
REQ-017 RUN: prescaler SHALL count 0..TICKS_PER_SEC-1 each cycle pause=0, wrapping to 0; terminal count = one tick.
REQ-018 pause=1 SHALL hold prescaler and digits unchanged; resume continues from held prescaler value.
REQ-019 On tick, value SHALL decrement by one in BCD: ones>0 -> ones-1; ones=0 -> ones=9, tens-1.
REQ-020 Tick taking 01 -> 00 SHALL enter DONE; expired=1 for exactly that one cycle, busy=0, seconds=9'h100.
REQ-021 DONE SHALL hold seconds=9'h100 until start or cancel; expired SHALL not repeat.
REQ-022 start in RUN SHALL be ignored; no reload, prescaler continues.
REQ-023 cancel in RUN or DONE SHALL enter IDLE next cycle, seconds=9'h000, busy=0, no expired pulse.
REQ-024 start and cancel same cycle: cancel SHALL win.
REQ-025 Tick and cancel same cycle, including 01 tick: cancel SHALL win, no expired pulse.
REQ-026 Tick and start same cycle in RUN: tick SHALL be taken, start ignored.
REQ-027 seconds[7:0] SHALL always be valid BCD, each nibble 0..9.
REQ-028 Prescaler width SHALL be clog2(TICKS_PER_SEC); no overflow past TICKS_PER_SEC-1.

Reset
REQ-029 reset low SHALL at once force IDLE, prescaler=0, latched value=00, seconds=9'h000, busy=0, expired=0, in any state.
REQ-030 After reset release, first start SHALL act exactly as REQ-013; no pulse or residue from pre-reset state.

Verification
REQ-031 load 8'h03, start: seconds 9'h103 -> 102 -> 101 -> 100 at 4-cycle spacing; expired one cycle with 9'h100; busy drops then.
REQ-032 load 8'h10, start: after first tick seconds=9'h109 (borrow); after 10 ticks 9'h100 with expired.
REQ-033 load 8'h05, start, pause high 10 cycles mid-second: digits and prescaler frozen; total time to expired = 20+10 cycles.
REQ-034 load 8'h02, tick cycle of 01->00 with cancel high: seconds=9'h000, expired never asserts.
REQ-035 load 8'hAF then start: seconds=9'h199; load 8'h00 start: expired next cycle, seconds=9'h100; start+cancel same cycle from DONE: IDLE.
REQ-036 reset low mid-RUN at seconds=9'h107: all outputs zero asynchronously; after release stays IDLE until start.
